// File: rtl/uart_alu_pkg.sv
// Shared types and widths for the UART byte-stream blocks.
package uart_alu_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin pick: first requester set after i_ptr, wrapping modulo N.
module rr_arbiter_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_pick_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_any_c
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_pick_c = '0;
    o_idx_c  = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found           = 1'b1;
        o_idx_c           = w_cand;
        o_pick_c[w_cand]  = 1'b1;
      end
    end
  end

  assign o_any_c = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding uart_tx with one registered output stage.
// Optional stall timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*BYTE_W-1:0] s_data_i,
  input  logic [NUM_REQ-1:0]        s_valid_i,
  input  logic [NUM_REQ-1:0]        s_last_i,
  output logic [NUM_REQ-1:0]        s_ready_o,
  output logic [BYTE_W-1:0]         m_data_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e          r_state, w_next_state;
  logic [IW-1:0]       r_g, r_ptr, w_g_d, w_ptr_d;
  logic [BYTE_W-1:0]   r_m_data, w_m_data_d;
  logic                r_m_valid, w_m_valid_d;
  logic [NUM_REQ-1:0]  r_grant, w_grant_d;
  logic                r_busy, w_busy_d;
  logic                r_timeout, w_timeout_d;

  logic [NUM_REQ-1:0]  w_pick;
  logic [IW-1:0]       w_pick_idx;
  logic                w_any;
  logic                w_rdy, w_xfer, w_tmo, w_release;
  logic [BYTE_W-1:0]   w_byte;

  rr_arbiter_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req    (s_valid_i),
    .i_ptr    (r_ptr),
    .o_pick_c (w_pick),
    .o_idx_c  (w_pick_idx),
    .o_any_c  (w_any)
  );

  assign w_rdy     = !r_m_valid || m_ready_i;
  assign w_xfer    = (r_state == ARB_LOCKED) && s_valid_i[r_g] && w_rdy;
  assign w_byte    = s_data_i[32'(r_g)*BYTE_W +: BYTE_W];
  assign w_release = (w_xfer && s_last_i[r_g]) || w_tmo;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES);
  logic [STALL_W-1:0] r_stall;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled LOCKED cycle.
  assign w_tmo = (r_state == ARB_LOCKED) && !s_valid_i[r_g] &&
                 (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (r_state != ARB_LOCKED || w_xfer || w_tmo) begin
      r_stall <= '0;
    end else if (!s_valid_i[r_g]) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_g       <= '0;
      r_ptr     <= IW'(NUM_REQ - 1);
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_g       <= w_g_d;
      r_ptr     <= w_ptr_d;
      r_m_data  <= w_m_data_d;
      r_m_valid <= w_m_valid_d;
      r_grant   <= w_grant_d;
      r_busy    <= w_busy_d;
      r_timeout <= w_timeout_d;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any)     w_next_state = ARB_LOCKED;
      ARB_LOCKED: if (w_release) w_next_state = ARB_IDLE;
      default:                   w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o   = '0;
    w_g_d       = r_g;
    w_ptr_d     = r_ptr;
    w_grant_d   = r_grant;
    w_busy_d    = r_busy;
    w_timeout_d = 1'b0;
    w_m_data_d  = r_m_data;
    w_m_valid_d = r_m_valid;

    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_g_d     = w_pick_idx;
          w_grant_d = w_pick;
          w_busy_d  = 1'b1;
        end
      end
      ARB_LOCKED: begin
        s_ready_o[r_g] = w_rdy;
        if (w_release) begin
          w_ptr_d     = r_g;
          w_grant_d   = '0;
          w_busy_d    = 1'b0;
          w_timeout_d = w_tmo;
        end
      end
      default: ;
    endcase

    // Output register: load on transfer, drain when the sink takes the byte.
    if (w_xfer) begin
      w_m_data_d  = w_byte;
      w_m_valid_d = 1'b1;
    end else if (m_ready_i && r_m_valid) begin
      w_m_valid_d = 1'b0;
    end
  end

  assign m_data_o  = r_m_data;
  assign m_valid_o = r_m_valid;
  assign grant_o   = r_grant;
  assign busy_o    = r_busy;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2); timeout scenario follows UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data_i;
  logic [1:0]  s_valid_i;
  logic [1:0]  s_last_i;
  logic [1:0]  s_ready_o;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_last_i  (s_last_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    s_data_i  = '0;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b1;
    repeat (2) cyc();
    check_eq("rst_mvalid", 32'(m_valid_o), 32'h0);
    check_eq("rst_mdata",  32'(m_data_o),  32'h0);
    check_eq("rst_grant",  32'(grant_o),   32'h0);
    check_eq("rst_busy",   32'(busy_o),    32'h0);
    check_eq("rst_tmo",    32'(timeout_o), 32'h0);
    check_eq("rst_sready", 32'(s_ready_o), 32'h0);
    rst = 1'b1;

    // Three-byte packet from req0 alone
    s_valid_i = 2'b01; s_data_i[7:0] = 8'h41; s_last_i = 2'b00;
    cyc();
    check_eq("t1_grant", 32'(grant_o),   32'h1);
    check_eq("t1_busy",  32'(busy_o),    32'h1);
    check_eq("t1_srdy",  32'(s_ready_o), 32'h1);
    check_eq("t1_mv0",   32'(m_valid_o), 32'h0);
    cyc();
    check_eq("t1_b0",    32'(m_data_o),  32'h41);
    check_eq("t1_mv1",   32'(m_valid_o), 32'h1);
    s_data_i[7:0] = 8'h42;
    cyc();
    check_eq("t1_b1",    32'(m_data_o),  32'h42);
    s_data_i[7:0] = 8'h43; s_last_i = 2'b01;
    cyc();
    check_eq("t1_b2",    32'(m_data_o),  32'h43);
    check_eq("t1_busy0", 32'(busy_o),    32'h0);
    check_eq("t1_gnt0",  32'(grant_o),   32'h0);
    s_valid_i = 2'b00; s_last_i = 2'b00;
    cyc();
    check_eq("t1_drain", 32'(m_valid_o), 32'h0);
    // ptr now 0: req1 wins a simultaneous request
    s_valid_i = 2'b11; s_data_i = {8'hC1, 8'hC0}; s_last_i = 2'b11;
    cyc();
    check_eq("t1_ptr",   32'(grant_o),   32'h2);
    cyc();
    check_eq("t1_ptrb",  32'(m_data_o),  32'hC1);
    s_valid_i = 2'b00; s_last_i = 2'b00;
    rst = 1'b0;
    cyc();
    rst = 1'b1;

    // Round-robin with single-byte packets
    s_data_i = {8'hB0, 8'hA0}; s_valid_i = 2'b11; s_last_i = 2'b11;
    cyc();
    check_eq("t2_g0",    32'(grant_o),   32'h1);
    cyc();
    check_eq("t2_dA",    32'(m_data_o),  32'hA0);
    check_eq("t2_vA",    32'(m_valid_o), 32'h1);
    check_eq("t2_rel",   32'(grant_o),   32'h0);
    s_valid_i = 2'b10;
    cyc();
    check_eq("t2_bub",   32'(m_valid_o), 32'h0);
    check_eq("t2_g1",    32'(grant_o),   32'h2);
    cyc();
    check_eq("t2_dB",    32'(m_data_o),  32'hB0);
    check_eq("t2_rel1",  32'(grant_o),   32'h0);
    s_valid_i = 2'b11;
    cyc();
    check_eq("t2_g0b",   32'(grant_o),   32'h1);
    check_eq("t2_bub2",  32'(m_valid_o), 32'h0);
    cyc();
    check_eq("t2_dA2",   32'(m_data_o),  32'hA0);
    s_valid_i = 2'b00; s_last_i = 2'b00;

    // Backpressure holds the output register
    s_valid_i = 2'b01; s_data_i[7:0] = 8'h55; s_last_i = 2'b00;
    cyc();
    check_eq("t3_grant", 32'(grant_o),   32'h1);
    cyc();
    check_eq("t3_d55",   32'(m_data_o),  32'h55);
    m_ready_i = 1'b0; s_data_i[7:0] = 8'h56; s_last_i = 2'b01;
    #1;
    check_eq("t3_srdy0", 32'(s_ready_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("t3_hold_d", 32'(m_data_o),  32'h55);
      check_eq("t3_hold_v", 32'(m_valid_o), 32'h1);
      check_eq("t3_hold_r", 32'(s_ready_o), 32'h0);
    end
    m_ready_i = 1'b1;
    #1;
    check_eq("t3_srdy1", 32'(s_ready_o), 32'h1);
    cyc();
    check_eq("t3_d56",   32'(m_data_o),  32'h56);
    check_eq("t3_v56",   32'(m_valid_o), 32'h1);
    check_eq("t3_gnt0",  32'(grant_o),   32'h0);
    s_valid_i = 2'b00; s_last_i = 2'b00;
    cyc();
    check_eq("t3_drain", 32'(m_valid_o), 32'h0);

    // Gap inside req0 packet while req1 waits
    s_valid_i = 2'b01; s_data_i[7:0] = 8'h10; s_last_i = 2'b00;
    cyc();
    check_eq("t4_grant", 32'(grant_o),   32'h1);
    s_valid_i = 2'b11; s_data_i[15:8] = 8'h99; s_last_i = 2'b10;
    cyc();
    check_eq("t4_d10",   32'(m_data_o),  32'h10);
    s_valid_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("t4_gap_g", 32'(grant_o),   32'h1);
      check_eq("t4_gap_r", 32'(s_ready_o), 32'h1);
      check_eq("t4_gap_v", 32'(m_valid_o), 32'h0);
    end
    s_valid_i = 2'b11; s_data_i[7:0] = 8'h11; s_last_i = 2'b11;
    cyc();
    check_eq("t4_d11",   32'(m_data_o),  32'h11);
    check_eq("t4_v11",   32'(m_valid_o), 32'h1);
    check_eq("t4_rel",   32'(grant_o),   32'h0);
    s_valid_i = 2'b10;
    cyc();
    check_eq("t4_g1",    32'(grant_o),   32'h2);
    cyc();
    check_eq("t4_d99",   32'(m_data_o),  32'h99);
    s_valid_i = 2'b00; s_last_i = 2'b00;

    // Asynchronous reset mid-packet
    s_valid_i = 2'b01; s_data_i[7:0] = 8'h77; s_last_i = 2'b00;
    cyc();
    check_eq("t5_grant", 32'(grant_o),   32'h1);
    cyc();
    check_eq("t5_d77",   32'(m_data_o),  32'h77);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_mv",    32'(m_valid_o), 32'h0);
    check_eq("t5_md",    32'(m_data_o),  32'h0);
    check_eq("t5_gnt",   32'(grant_o),   32'h0);
    check_eq("t5_busy",  32'(busy_o),    32'h0);
    check_eq("t5_srdy",  32'(s_ready_o), 32'h0);
    s_valid_i = 2'b11; s_data_i = {8'hB5, 8'hA5}; s_last_i = 2'b11;
    cyc();
    rst = 1'b1;
    cyc();
    check_eq("t5_g0",    32'(grant_o),   32'h1);
    cyc();
    check_eq("t5_dA5",   32'(m_data_o),  32'hA5);
    s_valid_i = 2'b00; s_last_i = 2'b00;

    // Stalled packet: timeout release or indefinite lock
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    s_valid_i = 2'b01; s_data_i[7:0] = 8'h20; s_last_i = 2'b00;
    cyc();
    check_eq("t6_grant", 32'(grant_o),   32'h1);
    cyc();
    check_eq("t6_d20",   32'(m_data_o),  32'h20);
    s_valid_i = 2'b10; s_data_i[15:8] = 8'h33; s_last_i = 2'b10;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      cyc();
      check_eq("t6_pre",  32'(timeout_o), 32'h0);
    end
    cyc();
    check_eq("t6_pulse", 32'(timeout_o), 32'h1);
    check_eq("t6_relg",  32'(grant_o),   32'h0);
    cyc();
    check_eq("t6_post",  32'(timeout_o), 32'h0);
    check_eq("t6_g1",    32'(grant_o),   32'h2);
`else
    for (int i = 0; i < 30; i++) begin
      cyc();
      check_eq("t6_nopulse", 32'(timeout_o), 32'h0);
    end
    check_eq("t6_starve", 32'(grant_o),   32'h1);
    check_eq("t6_srdy",   32'(s_ready_o), 32'h1);
`endif
    s_valid_i = 2'b00; s_last_i = 2'b00;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
